// File: rtl/operand_mac.sv
// Four-operand multiply-accumulate (A*B + C*D), loaded one switch value per button press.
// Define MAC_OVF_SAT_EN to saturate PROD on overflow; otherwise PROD wraps.
module operand_mac #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [WIDTH-1:0]   SW,
    input  logic               LOAD_N,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   C,
    output logic [WIDTH-1:0]   D,
    output logic [2*WIDTH-1:0] PROD,
    output logic [1:0]         STEP,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVF
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AccW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {
        StLdA, StLdB, StLdC, StLdD, StMulAb, StMulCd, StResult
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q, hist_q;
    logic                load_evt;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic                ovf_q, ovf_d;
    logic [WIDTH-1:0]    mcand;
    logic                mul_bit;
    logic [AccW-1:0]     mcand_ext, addend, acc_sum;
    logic                last_cnt;

    // Synchronized high-to-low transition of the push-button.
    assign load_evt = hist_q & ~sync2_q;
    assign last_cnt = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        mcand     = (state_q == StMulCd) ? c_q : a_q;
        mul_bit   = (state_q == StMulCd) ? d_q[cnt_q] : b_q[cnt_q];
        mcand_ext = {{(WIDTH + 1){1'b0}}, mcand};
        addend    = mul_bit ? (mcand_ext << cnt_q) : '0;
        acc_sum   = acc_q + addend;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StLdA: if (load_evt) begin
                a_d     = SW;
                state_d = StLdB;
            end
            StLdB: if (load_evt) begin
                b_d     = SW;
                state_d = StLdC;
            end
            StLdC: if (load_evt) begin
                c_d     = SW;
                state_d = StLdD;
            end
            StLdD: if (load_evt) begin
                d_d     = SW;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StMulAb;
            end
            StMulAb: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CntW'(1);
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = StMulCd;
                end
            end
            StMulCd: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CntW'(1);
                if (last_cnt) begin
                    cnt_d   = '0;
                    ovf_d   = acc_sum[2*WIDTH];
`ifdef MAC_OVF_SAT_EN
                    prod_d  = acc_sum[2*WIDTH] ? '1 : acc_sum[2*WIDTH-1:0];
`else
                    prod_d  = acc_sum[2*WIDTH-1:0];
`endif
                    state_d = StResult;
                end
            end
            StResult: if (load_evt) begin
                a_d     = SW;
                state_d = StLdB;
            end
            default: state_d = StLdA;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            state_q <= StLdA;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= LOAD_N;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        STEP = 2'd0;
        unique case (state_q)
            StLdB:            STEP = 2'd1;
            StLdC:            STEP = 2'd2;
            StLdD:            STEP = 2'd3;
            StMulAb, StMulCd: STEP = 2'd3;
            default:          STEP = 2'd0;
        endcase
    end

    assign A    = a_q;
    assign B    = b_q;
    assign C    = c_q;
    assign D    = d_q;
    assign PROD = prod_q;
    assign OVF  = ovf_q;
    assign BUSY = (state_q == StMulAb) || (state_q == StMulCd);
    assign DONE = (state_q == StResult);

endmodule

// File: doc/operand_mac.md
OPERAND_MAC -- requirements
Module: operand_mac

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width in bits.
REQ-002 The block SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port SW, input, WIDTH, operand value from the board switches.
REQ-005 The block SHALL have port LOAD_N, input, 1, active-low push-button; asynchronous to CLK.
REQ-006 The block SHALL have ports A, B, C, D, output, WIDTH each, the registered operands.
REQ-007 The block SHALL have port PROD, output, 2*WIDTH, the registered result A*B + C*D.
REQ-008 The block SHALL have port STEP, output, 2, the next operand slot to load: 0=A, 1=B, 2=C, 3=D.
REQ-009 The block SHALL have ports BUSY, DONE, OVF, output, 1 each: compute in progress, result valid, result exceeded 2*WIDTH bits.

Function
REQ-010 LOAD_N SHALL pass through a two-flop synchronizer plus one history flop; a load event is a synchronized high-to-low transition.
REQ-011 Each load event SHALL capture SW on the third rising CLK edge after LOAD_N falls; a held-low LOAD_N yields exactly one event.
REQ-012 FSM states SHALL be LD_A, LD_B, LD_C, LD_D, MUL_AB, MUL_CD, RESULT.
REQ-013 In LD_x, a load event SHALL capture SW into register x and advance to the next state: LD_A->LD_B->LD_C->LD_D->MUL_AB.
REQ-014 MUL_AB SHALL run exactly WIDTH cycles of shift-add (multiplier B, LSB first) into a 2*WIDTH+1-bit accumulator cleared on entry; MUL_CD SHALL run exactly WIDTH cycles with multiplicand C and multiplier D, adding into the same accumulator.
REQ-015 Timing: if the edge capturing D is edge 0, BUSY SHALL be 1 after edges 0 through 2*WIDTH-1; on edge 2*WIDTH, PROD/OVF update, BUSY falls, DONE rises, and the state enters RESULT.
REQ-016 PROD and OVF SHALL hold their previous values while BUSY=1; no intermediate accumulator value is ever visible on PROD.
REQ-017 OVF SHALL equal accumulator bit 2*WIDTH; PROD SHALL equal accumulator bits 2*WIDTH-1:0, except as modified by REQ-024.
REQ-018 Load events while BUSY=1 SHALL be ignored and discarded; no queued capture.
REQ-019 In RESULT, a load event SHALL capture SW into A, clear DONE, and go to LD_B; B, C, D, PROD and OVF keep their values until overwritten.
REQ-020 STEP SHALL be 0/1/2/3 in LD_A/LD_B/LD_C/LD_D, 3 during MUL_AB and MUL_CD, and 0 in RESULT.
REQ-021 Zero operands SHALL need no special case and SHALL still take 2*WIDTH cycles.

Reset
REQ-022 With RST_N low, A, B, C, D, PROD, accumulator = 0; BUSY = DONE = OVF = 0; STEP = 0; state = LD_A; synchronizer and history flops = 1, so no spurious load event occurs on release.
REQ-023 Reset asserted mid-compute SHALL abort at once; the next load event after release SHALL capture A.

Configuration
REQ-024 Macro MAC_OVF_SAT_EN: when defined, PROD SHALL saturate to all ones whenever OVF=1; when undefined, PROD SHALL wrap modulo 2^(2*WIDTH). OVF is reported in both builds.

Verification
REQ-025 Load sequence A=0x12, B=0x34, C=0x05, D=0x06 SHALL give BUSY for 16 cycles, then PROD=0x03C6, OVF=0, DONE=1.
REQ-026 Load sequence A=B=C=D=0xFF SHALL give OVF=1, with PROD=0xFC02 when MAC_OVF_SAT_EN is undefined and PROD=0xFFFF when it is defined.
REQ-027 Pressing LOAD_N at BUSY cycle 5 with SW=0x77 SHALL leave A through D unchanged and give PROD=0x03C6 per REQ-025; STEP SHALL read 0 after DONE.
REQ-028 Holding LOAD_N low for 100 cycles in LD_A with SW=0xAB SHALL give A=0xAB, STEP=1, and leave B unchanged.
REQ-029 Driving RST_N low at BUSY cycle 8 SHALL zero all outputs; after release, SW=0x09 plus one press SHALL give A=0x09 and STEP=1.
REQ-030 In RESULT, pressing LOAD_N with SW=0x02 SHALL give A=0x02, DONE=0, STEP=1, and leave PROD unchanged.
